// File: rtl/rr_arb_fsm_if.sv
// Request/grant bundle between the requesting agents and the rr_arb_fsm arbiter.
// The master side drives the requests, and the slave side (the arbiter) returns the grant.
interface rr_arb_fsm_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;
  logic            timeout;

  modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arb_fsm.sv
// N-requester grant arbiter with a registered one-hot grant.
// It supports round-robin or fixed-priority selection and a bounded hold time.
// When a grant is force-released, the arbiter inserts a one-cycle cool-down with a timeout pulse.
// The grant moves directly from one owner to the next, with no idle cycle between owners.
module rr_arb_fsm #(
  parameter int NREQ      = 4,
  parameter int MAX_HOLD  = 8,
  parameter int PRIO_MODE = 0,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic        clock,
  input  logic        reset_n,
  rr_arb_fsm_if.slave bus
);

  // The hold counter only ever reaches MAX_HOLD-1, so this width never wraps.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST  = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDW-1:0]  LAST_RESET = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0   = NREQ'(1);

  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            gnt_valid_q;
  logic            timeout_q, timeout_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [IDW-1:0]  last_q, last_d;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] search;
  int              offset;
  int              win_pos;
  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic            owner_req;

  // Pick a winner among the pending requests, excluding the current owner.
  // In round-robin mode, the request vector is rotated so the search starts just after the last winner.
  always_comb begin
    cand      = bus.req & ~gnt_q;
    search    = cand;
    offset    = 0;
    if (PRIO_MODE == 0) begin
      search = NREQ'({cand, cand} >> (int'(last_q) + 1));
      offset = int'(last_q) + 1;
    end
    win_found = |search;
    win_pos   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (search[i]) win_pos = i;
    end
    win_id    = IDW'((win_pos + offset) % NREQ);
    owner_req = |(bus.req & gnt_q);
  end

  // Next-state and next-output logic. The grant is kept unless the owner drops its request or the hold limit ends it.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    last_d    = last_q;
    case (state_q)
      IDLE, COOL: begin
        if (win_found) begin
          state_d  = GRANT;
          gnt_d    = ONE_HOT0 << win_id;
          gnt_id_d = win_id;
          hold_d   = '0;
          last_d   = win_id;
        end else begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (win_found) begin
            gnt_d    = ONE_HOT0 << win_id;
            gnt_id_d = win_id;
            hold_d   = '0;
            last_d   = win_id;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
          state_d   = COOL;
          gnt_d     = '0;
          gnt_id_d  = '0;
          timeout_d = 1'b1;
          hold_d    = '0;
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        hold_d   = '0;
      end
    endcase
  end

  // State and output registers. Reset restarts the rotation at requester 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_q      <= '0;
      last_q      <= LAST_RESET;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= |gnt_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb_fsm.sv
// Testbench for rr_arb_fsm.
// Three instances are driven: round-robin with hold limit 8, round-robin with no hold limit, and fixed priority with hold limit 8.
// Expected grant and timeout values are queued when a request pattern is driven.
// They are popped and compared one clock later, after the DUT has registered its response.
`timescale 1ns/1ps
module tb_rr_arb_fsm;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  rr_arb_fsm_if #(.NREQ(4)) if_rr ();
  rr_arb_fsm_if #(.NREQ(4)) if_nh ();
  rr_arb_fsm_if #(.NREQ(4)) if_fp ();

  rr_arb_fsm #(.NREQ(4), .MAX_HOLD(8), .PRIO_MODE(0)) dut_rr (
    .clock(clock), .reset_n(reset_n), .bus(if_rr));
  rr_arb_fsm #(.NREQ(4), .MAX_HOLD(0), .PRIO_MODE(0)) dut_nh (
    .clock(clock), .reset_n(reset_n), .bus(if_nh));
  rr_arb_fsm #(.NREQ(4), .MAX_HOLD(8), .PRIO_MODE(1)) dut_fp (
    .clock(clock), .reset_n(reset_n), .bus(if_fp));

  typedef struct {
    logic [3:0] gnt;
    logic       tmo;
  } exp_t;

  exp_t       sb_q[$];
  int         chk_cnt = 0;
  int         err_cnt = 0;
  logic [3:0] oh_a, oh_b;

  function automatic logic [1:0] id_of(input logic [3:0] g);
    id_of = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) id_of = 2'(i);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one request pattern into the selected instance and queue the expected response.
  // Then wait one clock edge, pop the expectation, and compare it with the instance outputs.
  task automatic applyStimulus(input int sel, input string tag, input logic [3:0] r,
                               input logic [3:0] exp_gnt, input logic exp_tmo);
    exp_t       e;
    logic [3:0] ag  = '0;
    logic [1:0] aid = '0;
    logic       av  = 1'b0;
    logic       at  = 1'b0;
    if_rr.req = (sel == 0) ? r : 4'b0000;
    if_nh.req = (sel == 1) ? r : 4'b0000;
    if_fp.req = (sel == 2) ? r : 4'b0000;
    e.gnt = exp_gnt;
    e.tmo = exp_tmo;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    case (sel)
      0: begin ag = if_rr.gnt; aid = if_rr.gnt_id; av = if_rr.gnt_valid; at = if_rr.timeout; end
      1: begin ag = if_nh.gnt; aid = if_nh.gnt_id; av = if_nh.gnt_valid; at = if_nh.timeout; end
      default: begin ag = if_fp.gnt; aid = if_fp.gnt_id; av = if_fp.gnt_valid; at = if_fp.timeout; end
    endcase
    e = sb_q.pop_front();
    checkOutput({tag, ".gnt"}, 32'(ag), 32'(e.gnt));
    checkOutput({tag, ".gnt_id"}, 32'(aid), 32'(id_of(e.gnt)));
    checkOutput({tag, ".gnt_valid"}, 32'(av), 32'(|e.gnt));
    checkOutput({tag, ".timeout"}, 32'(at), 32'(e.tmo));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    if_rr.req = 4'b0000;
    if_nh.req = 4'b0000;
    if_fp.req = 4'b0000;

    // Reset with every request high, then the first grant after release.
    applyStimulus(0, "t1_reset", 4'b1111, 4'b0000, 1'b0);
    applyStimulus(0, "t1_reset", 4'b1111, 4'b0000, 1'b0);
    reset_n = 1'b1;
    applyStimulus(0, "t1_first", 4'b1111, 4'b0001, 1'b0);

    // Round-robin hand-over: each owner holds for one more cycle, then drops its request.
    for (int o = 0; o < 4; o++) begin
      oh_a = 4'b0001 << o;
      oh_b = 4'b0001 << ((o + 1) % 4);
      applyStimulus(0, "t2_hold", 4'b1111, oh_a, 1'b0);
      applyStimulus(0, "t2_switch", 4'b1111 & ~oh_a, oh_b, 1'b0);
    end

    // Reset in the middle of a grant held by requester 2.
    applyStimulus(0, "t6_hold0", 4'b1111, 4'b0001, 1'b0);
    applyStimulus(0, "t6_to1", 4'b1110, 4'b0010, 1'b0);
    applyStimulus(0, "t6_hold1", 4'b1111, 4'b0010, 1'b0);
    applyStimulus(0, "t6_to2", 4'b1101, 4'b0100, 1'b0);
    reset_n = 1'b0;
    applyStimulus(0, "t6_reset", 4'b1111, 4'b0000, 1'b0);
    reset_n = 1'b1;
    applyStimulus(0, "t6_first", 4'b1111, 4'b0001, 1'b0);
    applyStimulus(0, "t6_next", 4'b1110, 4'b0010, 1'b0);

    // A single requester hits the hold limit, cools down for one cycle, and then wins again.
    reset_n = 1'b0;
    applyStimulus(0, "t3_reset", 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 8; k++) applyStimulus(0, "t3_grant", 4'b0010, 4'b0010, 1'b0);
      applyStimulus(0, "t3_cool", 4'b0010, 4'b0000, 1'b1);
    end
    applyStimulus(0, "t3_regrant", 4'b0010, 4'b0010, 1'b0);

    // With all requests held, each timeout passes the grant to the next requester in rotation.
    reset_n = 1'b0;
    applyStimulus(0, "trot_reset", 4'b1111, 4'b0000, 1'b0);
    reset_n = 1'b1;
    for (int o = 0; o < 4; o++) begin
      oh_a = 4'b0001 << o;
      for (int k = 0; k < 8; k++) applyStimulus(0, "trot_grant", 4'b1111, oh_a, 1'b0);
      applyStimulus(0, "trot_cool", 4'b1111, 4'b0000, 1'b1);
    end
    applyStimulus(0, "trot_wrap", 4'b1111, 4'b0001, 1'b0);

    // With no hold limit, a grant never times out.
    for (int k = 0; k < 100; k++) applyStimulus(1, "t4_nolimit", 4'b0001, 4'b0001, 1'b0);

    // Fixed priority: a lower index never pre-empts the current owner, and a timed-out owner is re-granted.
    for (int k = 0; k < 3; k++) applyStimulus(2, "t5_low", 4'b1010, 4'b0010, 1'b0);
    applyStimulus(2, "t5_drop1", 4'b1000, 4'b1000, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(2, "t5_keep3", 4'b1001, 4'b1000, 1'b0);
    applyStimulus(2, "t5_drop3", 4'b0001, 4'b0001, 1'b0);
    for (int k = 0; k < 7; k++) applyStimulus(2, "t5_hold0", 4'b0011, 4'b0001, 1'b0);
    applyStimulus(2, "t5_cool", 4'b0011, 4'b0000, 1'b1);
    applyStimulus(2, "t5_regrant", 4'b0011, 4'b0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
